// File: rtl/apple1_pkg.sv
// Shared constants and helpers for the Apple-1 horizontal timing chain.
// HCOUNT_DEBUG_EN (in apple1_htiming) exposes units/tens as ports.
package apple1_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DOT_LOAD     = 4'b1010;
  localparam cnt_t UNITS_RELOAD = 4'd5;
  localparam cnt_t TENS_RELOAD  = 4'd9;
  localparam cnt_t DEC_TOP      = 4'd9;
  localparam cnt_t BIN_TOP      = 4'd15;

  function automatic cnt_t cnt_next(
    input cnt_t q,
    input logic decade
  );
    cnt_t r;
    r = q + cnt_t'(1);
    if (decade && q == DEC_TOP)
      r = '0;
    return r;
  endfunction

  function automatic logic cnt_tc(
    input cnt_t q,
    input logic decade
  );
    return decade ? (q == DEC_TOP) : (q == BIN_TOP);
  endfunction

endpackage

// File: rtl/apple1_htiming_counter.sv
// 4-bit synchronous counter: enable, priority sync load, async clear,
// terminal count, decade or binary wrap.
module sync_counter4
  import apple1_pkg::*;
#(
  parameter bit DECADE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  input  cnt_t load_val,
  output cnt_t q,
  output logic tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (load)
      q <= load_val;
    else if (en)
      q <= cnt_next(q, DECADE);
  end

  assign tc = cnt_tc(q, DECADE);

endmodule

// File: rtl/apple1_htiming.sv
// Apple-1 horizontal timing: dot/char dividers and units/tens line count.
// Define HCOUNT_DEBUG_EN to bring units and tens out as ports.
module apple1_htiming
  import apple1_pkg::*;
(
  input  logic cp,
  input  logic mr_n,
  output logic dot_rate,
  output logic char_rate,
`ifdef HCOUNT_DEBUG_EN
  output cnt_t units,
  output cnt_t tens,
`endif
  output logic h10,
  output logic last_h,
  output logic hbl_n,
  output logic h_sync_n
);

`ifndef HCOUNT_DEBUG_EN
  cnt_t units;
  cnt_t tens;
`endif

  cnt_t dcnt;
  logic dcnt_tc;
  logic units_tc;
  logic tens_tc;
  logic dot_rise;
  logic char_rise;
  logic line_load;

  // Dividers run as enables on cp; the edges below mark the
  // cp cycle on which the derived clock would rise.
  assign dot_rise  = ~dot_rate;
  assign char_rise = dot_rise & ~char_rate;
  assign line_load = char_rise & last_h;

  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n)
      dot_rate <= 1'b1;
    else
      dot_rate <= ~dot_rate;
  end

  sync_counter4 #(
    .DECADE (1'b0)
  ) u_dcnt (
    .clk      (cp),
    .rst_n    (mr_n),
    .en       (dot_rise),
    .load     (char_rise),
    .load_val (DOT_LOAD),
    .q        (dcnt),
    .tc       (dcnt_tc)
  );

  sync_counter4 #(
    .DECADE (1'b1)
  ) u_units (
    .clk      (cp),
    .rst_n    (mr_n),
    .en       (char_rise),
    .load     (line_load),
    .load_val (UNITS_RELOAD),
    .q        (units),
    .tc       (units_tc)
  );

  sync_counter4 #(
    .DECADE (1'b0)
  ) u_tens (
    .clk      (cp),
    .rst_n    (mr_n),
    .en       (char_rise & h10),
    .load     (line_load),
    .load_val (TENS_RELOAD),
    .q        (tens),
    .tc       (tens_tc)
  );

  // dcnt wraps 1111->0000 on the same edge char_rate falls.
  assign char_rate = dcnt[3] | (dcnt_tc & 1'b0);

  assign h10      = units_tc;
  assign last_h   = units_tc & tens_tc;
  assign hbl_n    = tens[2];
  assign h_sync_n = tens[0] | hbl_n;

endmodule

// File: tb/tb_apple1_htiming.sv
// Randomized self-checking bench for apple1_htiming against a
// cycle-count arithmetic model of the horizontal timing.
`timescale 1ns/1ps
module tb_apple1_htiming;

  logic cp;
  logic mr_n;
  logic dot_rate;
  logic char_rate;
  logic h10;
  logic last_h;
  logic hbl_n;
  logic h_sync_n;
`ifdef HCOUNT_DEBUG_EN
  logic [3:0] units;
  logic [3:0] tens;
`endif

  int total = 0;
  int bad = 0;
  int k;
  bit run = 0;

  apple1_htiming dut (
    .cp       (cp),
    .mr_n     (mr_n),
    .dot_rate (dot_rate),
    .char_rate(char_rate),
`ifdef HCOUNT_DEBUG_EN
    .units    (units),
    .tens     (tens),
`endif
    .h10      (h10),
    .last_h   (last_h),
    .hbl_n    (hbl_n),
    .h_sync_n (h_sync_n)
  );

  initial cp = 1'b0;
  always #35 cp = ~cp;

  // cp edges since reset release
  always @(posedge cp or negedge mr_n) begin
    if (!mr_n) k <= 0;
    else k <= k + 1;
  end

  // horizontal position (tens*10+units) after n char edges
  function automatic int pos_of(input int n);
    if (n < 160) return n;
    return 95 + (n - 160) % 65;
  endfunction

  function automatic int chars_of(input int kk);
    int m;
    m = kk / 2;
    return (m == 0) ? 0 : (m - 1) / 7 + 1;
  endfunction

  // {dot,char,h10,last_h,hbl_n,h_sync_n,units[3:0],tens[3:0]}
  function automatic logic [13:0] model(input int kk);
    int m, c, u, t;
    logic dot, chr;
    m   = kk / 2;
    dot = (kk % 2) == 0;
    chr = (m > 0) && (((m - 1) % 7) < 6);
    c   = pos_of(chars_of(kk));
    u   = c % 10;
    t   = c / 10;
    return {dot, chr, u == 9, c == 159, ((t >> 2) & 1) == 1,
            (((t & 1) | ((t >> 2) & 1)) == 1), u[3:0], t[3:0]};
  endfunction

  function automatic logic [13:0] observed();
`ifdef HCOUNT_DEBUG_EN
    return {dot_rate, char_rate, h10, last_h, hbl_n, h_sync_n,
            units, tens};
`else
    return {dot_rate, char_rate, h10, last_h, hbl_n, h_sync_n, 8'h00};
`endif
  endfunction

`ifdef HCOUNT_DEBUG_EN
  localparam logic [13:0] MASK = 14'h3fff;
`else
  localparam logic [13:0] MASK = 14'h3f00;
`endif

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge cp) begin
    if (run) begin
      logic [13:0] e;
      logic [13:0] a;
      e = model(k) & MASK;
      a = observed() & MASK;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle k=%0d: got %h want %h", k, a, e);
      end
    end
  end

  task automatic check_reset_vals(input string name);
    check(name, int'({dot_rate, char_rate, h10, last_h, hbl_n, h_sync_n}),
          int'(6'b100000));
  endtask

  initial begin
    int cyc, cnt, sync_out, hb, hs;
    bit pc, pd;
    realtime td0, td1, tcr, tcf, tcr2;
    mr_n = 1'b0;
    #70;
    check_reset_vals("reset_vals");
    run = 1;
    @(posedge cp);
    #10 mr_n = 1'b1;
    @(posedge cp); #1;
    check("dot_after_1", int'(dot_rate), 0);
    check("char_after_1", int'(char_rate), 0);
    @(posedge cp); #1;
    check("dot_after_2", int'(dot_rate), 1);
    check("char_after_2", int'(char_rate), 1);

    // divider timing
    pd = dot_rate; pc = char_rate;
    td0 = 0; td1 = 0; tcr = 0; tcf = 0; tcr2 = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge cp); #1;
      if (dot_rate && !pd) begin
        if (td0 == 0) td0 = $realtime;
        else if (td1 == 0) td1 = $realtime;
      end
      if (char_rate && !pc) begin
        if (tcr == 0) tcr = $realtime;
        else if (tcr2 == 0) tcr2 = $realtime;
      end
      if (!char_rate && pc && tcr != 0 && tcf == 0) tcf = $realtime;
      pd = dot_rate; pc = char_rate;
    end
    check("dot_period_ns", int'(td1 - td0), 140);
    check("char_high_ns", int'(tcf - tcr), 840);
    check("char_period_ns", int'(tcr2 - tcr), 980);

    // first last_h after release: 159 char edges = 2214 cp edges
    cyc = 42;
    while (!last_h && cyc < 5000) begin
      @(posedge cp); #1;
      cyc++;
    end
    check("first_last_h_cp", cyc, 2214);

    // one steady line, last_h to last_h
    cyc = 0; cnt = 0; hb = 0; hs = 0; sync_out = 0;
    pc = char_rate;
    do begin
      @(posedge cp); #1;
      cyc++;
      if (char_rate && !pc) begin
        cnt++;
        if (!hbl_n) hb++;
        if (!h_sync_n) hs++;
        if (!h_sync_n && hbl_n) sync_out++;
      end
      pc = char_rate;
    end while (!(last_h && char_rate && cyc > 20) && cyc < 2000);
    check("line_cp", cyc, 910);
    check("line_chars", cnt, 65);
    check("blank_chars", hb, 25);
    check("sync_chars", hs, 10);
    check("sync_outside_blank", sync_out, 0);
    @(posedge cp); #1;
    while (last_h) begin @(posedge cp); #1; end
`ifdef HCOUNT_DEBUG_EN
    check("units_after_load", int'(units), 5);
    check("tens_after_load", int'(tens), 9);
`endif

    // random asynchronous resets
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(1, 2500)) @(posedge cp);
      #($urandom_range(5, 30)) mr_n = 1'b0;
      #1 check_reset_vals("async_reset");
      repeat ($urandom_range(1, 4)) @(posedge cp);
      #($urandom_range(5, 30)) mr_n = 1'b1;
    end

    // reset at tens=13, then first pass again
    cyc = 0;
    while ((pos_of(chars_of(k)) / 10) != 13 && cyc < 5000) begin
      @(posedge cp); #1;
      cyc++;
    end
    check("reached_tens13", pos_of(chars_of(k)) / 10, 13);
    #5 mr_n = 1'b0;
    #1 check_reset_vals("reset_tens13");
    @(posedge cp);
    #10 mr_n = 1'b1;
    cnt = 0; cyc = 0;
    pc = char_rate;
    while (!last_h && cyc < 4000) begin
      @(posedge cp); #1;
      cyc++;
      if (char_rate && !pc) cnt++;
      pc = char_rate;
    end
    check("first_load_edge", cnt + 1, 160);

    repeat (20) @(posedge cp);
    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
